// File: rtl/param_multi_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Holds the FSM state encoding, the default operand width and the counter-width helper.
package param_multi_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Enough bits to count from 0 up to and including width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/param_add_module.sv
// WIDTH-bit ripple adder with carry-out.
// Used once per CALC step for the conditional add into the upper accumulator half.
module param_add_module #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/param_multi_module.sv
// Sequential radix-2 shift-add multiplier, signed or unsigned, one step per clock.
// Operands are reduced to magnitudes at capture; the sign is reapplied in FINISH.
module param_multi_module
  import param_multi_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e               r_state;
  state_e               w_next_state;

  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_product;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_neg;

  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH-1:0]     w_sum;
  logic                 w_cout;
  logic [2*WIDTH-1:0]   w_step;
  logic [2*WIDTH-1:0]   w_final;

  // The most negative operand negates to 2^(WIDTH-1), which still fits WIDTH unsigned bits.
  assign w_a_neg = signed_mode & a[WIDTH-1];
  assign w_b_neg = signed_mode & b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;

  param_add_module #(
    .WIDTH(WIDTH)
  ) u_add (
    .i_a    (r_acc[2*WIDTH-1:WIDTH]),
    .i_b    (r_mcand),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Lower half holds the unconsumed multiplier bits; the carry re-enters at the top on the shift.
  assign w_step  = r_acc[0] ? {w_cout, w_sum, r_acc[WIDTH-1:1]}
                            : {1'b0, r_acc[2*WIDTH-1:1]};
  assign w_final = r_neg ? -r_acc : r_acc;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next_state = CALC;
      CALC:    if (r_cnt == LAST_STEP) w_next_state = FINISH;
      FINISH:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand   <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand <= w_a_mag;
            r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
            r_neg   <= w_a_neg ^ w_b_neg;
            r_cnt   <= '0;
          end
        end
        CALC: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        FINISH: begin
          r_product <= w_final;
        end
        default: begin
        end
      endcase
    end
  end

  // FINISH presents the signed result directly so it is valid together with done,
  // and the same value is held in r_product from then on.
  assign busy    = (r_state == CALC);
  assign done    = (r_state == FINISH);
  assign product = done ? w_final : r_product;

endmodule

// File: doc/param_multi_module.md
PARAM_MULTI_MODULE -- requirements
Module: param_multi_module

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The module SHALL have parameter CNT_W, default $clog2(WIDTH+1), giving the internal iteration-counter width.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-005 The module SHALL have port start, input, 1 bit: a one-cycle request to begin a multiply.
REQ-006 The module SHALL have port signed_mode, input, 1 bit: 1 = two's-complement operands, 0 = unsigned operands.
REQ-007 The module SHALL have port a, input, WIDTH bits: the multiplicand.
REQ-008 The module SHALL have port b, input, WIDTH bits: the multiplier.
REQ-009 The module SHALL have port busy, output, 1 bit: high while a multiply is in progress.
REQ-010 The module SHALL have port done, output, 1 bit: a one-cycle pulse marking that product is valid.
REQ-011 The module SHALL have port product, output, 2*WIDTH bits: the full-width result.

Function
REQ-012 The module SHALL implement an FSM with exactly three states: IDLE, CALC and FINISH.
REQ-013 In IDLE, start=1 SHALL capture a, b and signed_mode on that edge and move the FSM to CALC.
REQ-014 The captured operands SHALL be independent of any later change on a, b or signed_mode.
REQ-015 CALC SHALL last exactly WIDTH cycles, performing one radix-2 shift-add step per cycle on operand magnitudes.
REQ-016 Each CALC step SHALL test the current multiplier LSB, conditionally add the multiplicand into the upper accumulator half, and shift right by one.
REQ-017 In signed mode, each operand's magnitude SHALL be taken at capture, the operand -2^(WIDTH-1) SHALL give magnitude 2^(WIDTH-1), and the result SHALL be negated in FINISH when the operand signs differ.
REQ-018 FINISH SHALL last one cycle, load product, and return the FSM unconditionally to IDLE.
REQ-019 Timing from a start accepted on edge k: busy SHALL be 1 for cycles k+1..k+WIDTH, done SHALL be 1 in cycle k+WIDTH+1 only, and product SHALL be valid from cycle k+WIDTH+1.
REQ-020 busy and done SHALL never be 1 in the same cycle.
REQ-021 product SHALL hold its value until the next FINISH or reset.
REQ-022 start SHALL be ignored in CALC and FINISH, with no queuing.
REQ-023 Back-to-back operation SHALL be possible: a start in the cycle after done SHALL be accepted.
REQ-024 Arithmetic SHALL be exact over 2*WIDTH bits with no overflow or truncation for any operand pair.
REQ-025 A zero operand SHALL still take the full WIDTH CALC cycles, with no early exit.

Reset
REQ-026 rst=1 on a rising edge SHALL force the FSM to IDLE and clear busy, done, product, the accumulator and the counter to 0.
REQ-027 rst SHALL take priority over start when both are high in the same cycle.
REQ-028 An assertion of rst during CALC or FINISH SHALL abort the operation with no done pulse, and the aborted result SHALL never appear on product.

Structure
REQ-029 The FSM state typedef (IDLE/CALC/FINISH) SHALL reside in the shared package param_multi_pkg.
REQ-030 Package param_multi_pkg SHALL also hold the default WIDTH constant and a function returning the counter width.
REQ-031 The conditional add SHALL be done in one sub-module, param_add_module (WIDTH-bit adder with carry-out), instantiated once.
REQ-032 The design SHALL contain no other sub-modules and no combinational path from inputs to outputs.

Verification
REQ-033 The bench SHALL cover: WIDTH=8 unsigned, a=13, b=11, start -> done exactly 9 cycles later with product=143 (0x008F).
REQ-034 The bench SHALL cover: WIDTH=8 unsigned 255*255 -> product=0xFE01, and signed -128*-128 -> product=0x4000.
REQ-035 The bench SHALL cover: WIDTH=8 signed -3*5 -> product=0xFFF1, and signed 127*-1 -> product=0xFF81.
REQ-036 The bench SHALL cover: start during CALC with different operands -> ignored, with the first result and a single done pulse.
REQ-037 The bench SHALL cover: rst asserted 4 cycles into CALC -> busy=0 next cycle, product=0, no done, and a subsequent start then works normally.
REQ-038 The bench SHALL cover: WIDTH=4 instance, unsigned 15*15 -> product=225 (0xE1) with done 5 cycles after start, repeated back-to-back.
